// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 compare (feq/flt/fle) with optional fmin/fmax.
// Define FP_CMP_MINMAX_EN to build ops 3/4 as fmin/fmax; otherwise they behave as illegal ops.
module fp_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data1,
  input  logic [EXP_W+MAN_W:0]   in_data2,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [4:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_FLE = 3'd0;
  localparam logic [2:0] OP_FLT = 3'd1;
  localparam logic [2:0] OP_FEQ = 3'd2;
`ifdef FP_CMP_MINMAX_EN
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

  // Class vectors are {qnan, snan, zero}.
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [2:0]       s1_cls_a_q, s1_cls_a_d;
  logic [2:0]       s1_cls_b_q, s1_cls_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_result_q, s2_result_d;
  logic [4:0]       s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  logic             a_exp_ones;
  logic             b_exp_ones;
  logic [2:0]       in_cls_a;
  logic [2:0]       in_cls_b;

  logic             any_nan;
  logic             any_snan;
  logic             both_zero;
  logic             sign_a;
  logic             sign_b;
  logic             mag_lt;
  logic             mag_gt;
  logic             raw_lt;
  logic             ord_lt;
  logic             ord_eq;
  logic             cmp_bit;
  logic             nv;
  logic [W-1:0]     op_result;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    a_exp_ones = &in_data1[W-2:MAN_W];
    b_exp_ones = &in_data2[W-2:MAN_W];
    in_cls_a = {a_exp_ones & in_data1[MAN_W-1],
                a_exp_ones & ~in_data1[MAN_W-1] & (|in_data1[MAN_W-2:0]),
                ~|in_data1[W-2:0]};
    in_cls_b = {b_exp_ones & in_data2[MAN_W-1],
                b_exp_ones & ~in_data2[MAN_W-1] & (|in_data2[MAN_W-2:0]),
                ~|in_data2[W-2:0]};
  end

  // S1 only loads on an accepted request; an empty S1 keeps stale operands.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d     = in_data1;
        s1_b_d     = in_data2;
        s1_op_d    = in_op;
        s1_tag_d   = in_tag;
        s1_cls_a_d = in_cls_a;
        s1_cls_b_d = in_cls_b;
      end
    end
  end

  // raw_lt is a total order placing -0 below +0; ord_lt treats the zeros as equal.
  always_comb begin
    any_nan   = s1_cls_a_q[2] | s1_cls_a_q[1] | s1_cls_b_q[2] | s1_cls_b_q[1];
    any_snan  = s1_cls_a_q[1] | s1_cls_b_q[1];
    both_zero = s1_cls_a_q[0] & s1_cls_b_q[0];
    sign_a    = s1_a_q[W-1];
    sign_b    = s1_b_q[W-1];
    mag_lt    = s1_a_q[W-2:0] < s1_b_q[W-2:0];
    mag_gt    = s1_a_q[W-2:0] > s1_b_q[W-2:0];
    raw_lt    = (sign_a != sign_b) ? sign_a : (sign_a ? mag_gt : mag_lt);
    ord_lt    = raw_lt && !both_zero;
    ord_eq    = (s1_a_q == s1_b_q) || both_zero;
  end

  always_comb begin
    cmp_bit   = 1'b0;
    nv        = 1'b0;
    op_result = '0;
    case (s1_op_q)
      OP_FLE: begin
        cmp_bit   = !any_nan && (ord_lt || ord_eq);
        nv        = any_nan;
        op_result = {{(W-1){1'b0}}, cmp_bit};
      end
      OP_FLT: begin
        cmp_bit   = !any_nan && ord_lt;
        nv        = any_nan;
        op_result = {{(W-1){1'b0}}, cmp_bit};
      end
      OP_FEQ: begin
        cmp_bit   = !any_nan && ord_eq;
        nv        = any_snan;
        op_result = {{(W-1){1'b0}}, cmp_bit};
      end
`ifdef FP_CMP_MINMAX_EN
      OP_FMIN, OP_FMAX: begin
        nv = any_snan;
        if ((s1_cls_a_q[2] | s1_cls_a_q[1]) && (s1_cls_b_q[2] | s1_cls_b_q[1])) begin
          op_result = CANON_NAN;
        end else if (s1_cls_a_q[2] | s1_cls_a_q[1]) begin
          op_result = s1_b_q;
        end else if (s1_cls_b_q[2] | s1_cls_b_q[1]) begin
          op_result = s1_a_q;
        end else if ((s1_op_q == OP_FMIN) == raw_lt) begin
          op_result = s1_a_q;
        end else begin
          op_result = s1_b_q;
        end
      end
`endif
      default: begin
        cmp_bit   = 1'b0;
        nv        = 1'b0;
        op_result = '0;
      end
    endcase
  end

  // S2 holds its outputs while stalled so the consumer sees a stable result.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    s2_tag_d    = s2_tag_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = op_result;
        s2_flags_d  = {nv, 4'b0000};
        s2_tag_d    = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_cls_a_q  <= '0;
      s1_cls_b_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  always_comb begin
    out_valid  = s2_valid_q;
    out_result = s2_result_q;
    out_flags  = s2_flags_q;
    out_tag    = s2_tag_q;
  end

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Bench for fp_cmp_pipe: directed single/double vectors, random stream against a model, stalls and reset.
// Min/max expectations follow FP_CMP_MINMAX_EN in the same way as the design.
module tb_fp_cmp_pipe;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] res;
    logic [4:0]  fl;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic [63:0] a64;
  logic [63:0] b64;

  logic        in_ready_s, out_valid_s;
  logic [31:0] out_result_s;
  logic [4:0]  out_flags_s;
  logic [3:0]  out_tag_s;

  logic        in_ready_d, out_valid_d;
  logic [63:0] out_result_d;
  logic [4:0]  out_flags_d;
  logic [3:0]  out_tag_d;

  int errors;
  int checks;

  fp_cmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data1(a64[31:0]), .in_data2(b64[31:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_result(out_result_s),
    .out_flags(out_flags_s), .out_tag(out_tag_s)
  );

  fp_cmp_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut_d (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d),
    .in_data1(a64), .in_data2(b64), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_result(out_result_d),
    .out_flags(out_flags_d), .out_tag(out_tag_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Orders values through a signed integer key: -mag for negatives, +mag otherwise.
  function automatic void ref_model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                                    input int ew, input int mw,
                                    output logic [63:0] res, output logic [4:0] fl);
    int w;
    longint unsigned mag_mask, man_mask, exp_max, canon;
    longint unsigned ea, eb, ma, mb;
    logic sa, sb, nan_a, nan_b, snan_a, snan_b;
    longint ka, kb;
    w        = 1 + ew + mw;
    mag_mask = (64'd1 << (w - 1)) - 64'd1;
    man_mask = (64'd1 << mw) - 64'd1;
    exp_max  = (64'd1 << ew) - 64'd1;
    canon    = (exp_max << mw) | (64'd1 << (mw - 1));
    ea = (a >> mw) & exp_max;
    eb = (b >> mw) & exp_max;
    ma = a & man_mask;
    mb = b & man_mask;
    sa = a[w-1];
    sb = b[w-1];
    nan_a  = (ea == exp_max) && (ma != 0);
    nan_b  = (eb == exp_max) && (mb != 0);
    snan_a = nan_a && (((ma >> (mw - 1)) & 64'd1) == 0);
    snan_b = nan_b && (((mb >> (mw - 1)) & 64'd1) == 0);
    ka = sa ? -longint'(a & mag_mask) : longint'(a & mag_mask);
    kb = sb ? -longint'(b & mag_mask) : longint'(b & mag_mask);
    res = 64'd0;
    fl  = 5'd0;
    case (op)
      3'd0: if (nan_a || nan_b) fl = 5'h10; else res = (ka <= kb) ? 64'd1 : 64'd0;
      3'd1: if (nan_a || nan_b) fl = 5'h10; else res = (ka < kb) ? 64'd1 : 64'd0;
      3'd2: begin
        fl  = (snan_a || snan_b) ? 5'h10 : 5'h00;
        res = (!nan_a && !nan_b && ka == kb) ? 64'd1 : 64'd0;
      end
`ifdef FP_CMP_MINMAX_EN
      3'd3, 3'd4: begin
        fl = (snan_a || snan_b) ? 5'h10 : 5'h00;
        if (nan_a && nan_b) res = canon;
        else if (nan_a) res = b;
        else if (nan_b) res = a;
        else if (ka != kb) res = ((ka < kb) == (op == 3'd3)) ? a : b;
        else res = ((sa == 1'b1) == (op == 3'd3)) ? a : b;
      end
`endif
      default: begin
        res = 64'd0;
        fl  = 5'd0;
      end
    endcase
  endfunction

  function automatic logic [31:0] gen_operand(input logic [31:0] other);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: gen_operand = 32'h0000_0000;
      1: gen_operand = 32'h8000_0000;
      2: gen_operand = 32'h7F80_0000;
      3: gen_operand = 32'hFF80_0000;
      4: gen_operand = {r[31], 8'hFF, 1'b1, r[21:0]};
      5: gen_operand = {r[31], 8'hFF, 1'b0, r[21:0] | 22'd1};
      6: gen_operand = 32'h3F80_0000;
      7: gen_operand = other;
      8: gen_operand = other ^ 32'h8000_0000;
      default: gen_operand = r;
    endcase
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issues one op from a negedge with out_ready high; returns negedges from acceptance to out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input logic [3:0] tag, output int cyc);
    a64       = a;
    b64       = b;
    in_op     = op;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid_s && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a64 = '0; b64 = '0; in_op = '0; in_tag = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid_s !== 1'b0 || out_result_s !== 32'd0 || out_flags_s !== 5'd0 || out_tag_s !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b r=%h f=%h t=%h, expected v=0 r=0 f=0 t=0",
               out_valid_s, out_result_s, out_flags_s, out_tag_s);
    end
    checks++;
    if (in_ready_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_s);
    end
  endtask

  task automatic check_table(input string name, input vec_t q[$], input bit dbl);
    int cyc;
    for (int i = 0; i < q.size(); i++) begin
      run_op(q[i].a, q[i].b, q[i].op, 4'(i + 5), cyc);
      checks++;
      if (cyc !== 1 || out_valid_s !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_latency[%0d]: got %0d cycles valid=%b, expected 1 cycle valid=1",
                 name, i, cyc, out_valid_s);
      end
      if (dbl) begin
        checks++;
        if (out_valid_d !== 1'b1 || out_result_d !== q[i].res || out_flags_d !== q[i].fl || out_tag_d !== 4'(i + 5)) begin
          errors++;
          $display("[TB] FAIL %s[%0d]: got v=%b r=%h f=%h t=%h, expected r=%h f=%h t=%h", name, i,
                   out_valid_d, out_result_d, out_flags_d, out_tag_d, q[i].res, q[i].fl, 4'(i + 5));
        end
      end else begin
        checks++;
        if (out_result_s !== q[i].res[31:0] || out_flags_s !== q[i].fl || out_tag_s !== 4'(i + 5)) begin
          errors++;
          $display("[TB] FAIL %s[%0d]: got r=%h f=%h t=%h, expected r=%h f=%h t=%h", name, i,
                   out_result_s, out_flags_s, out_tag_s, q[i].res[31:0], q[i].fl, 4'(i + 5));
        end
      end
    end
  endtask

  task automatic test_compare_sp();
    vec_t q[$];
    q.push_back('{64'h3F800000, 64'h40000000, 3'd1, 64'd1, 5'h00});
    q.push_back('{64'h40000000, 64'h3F800000, 3'd0, 64'd0, 5'h00});
    q.push_back('{64'h80000000, 64'h00000000, 3'd2, 64'd1, 5'h00});
    q.push_back('{64'h80000000, 64'h00000000, 3'd1, 64'd0, 5'h00});
    q.push_back('{64'h80000000, 64'h00000000, 3'd0, 64'd1, 5'h00});
    q.push_back('{64'h7FC00000, 64'h3F800000, 3'd2, 64'd0, 5'h00});
    q.push_back('{64'h7F800001, 64'h3F800000, 3'd2, 64'd0, 5'h10});
    q.push_back('{64'h7FC00000, 64'h3F800000, 3'd1, 64'd0, 5'h10});
    q.push_back('{64'hC0000000, 64'hBF800000, 3'd1, 64'd1, 5'h00});
    q.push_back('{64'h3F800000, 64'h3F800000, 3'd0, 64'd1, 5'h00});
    q.push_back('{64'h3F800000, 64'h3F800000, 3'd6, 64'd0, 5'h00});
    check_table("compare_sp", q, 1'b0);
  endtask

  task automatic test_minmax_sp();
    vec_t q[$];
`ifdef FP_CMP_MINMAX_EN
    q.push_back('{64'h80000000, 64'h00000000, 3'd3, 64'h80000000, 5'h00});
    q.push_back('{64'h00000000, 64'h80000000, 3'd4, 64'h00000000, 5'h00});
    q.push_back('{64'h7FC00000, 64'hC0000000, 3'd4, 64'hC0000000, 5'h00});
    q.push_back('{64'h7F800001, 64'h7F800002, 3'd4, 64'h7FC00000, 5'h10});
    q.push_back('{64'hC0000000, 64'h3F800000, 3'd3, 64'hC0000000, 5'h00});
`else
    q.push_back('{64'h80000000, 64'h00000000, 3'd3, 64'd0, 5'h00});
    q.push_back('{64'h7F800001, 64'h7F800002, 3'd4, 64'd0, 5'h00});
`endif
    check_table("minmax_sp", q, 1'b0);
  endtask

  task automatic test_double();
    vec_t q[$];
    q.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 3'd1, 64'd1, 5'h00});
    q.push_back('{64'h4000000000000000, 64'h3FF0000000000000, 3'd0, 64'd0, 5'h00});
    q.push_back('{64'h8000000000000000, 64'h0000000000000000, 3'd2, 64'd1, 5'h00});
    q.push_back('{64'h8000000000000000, 64'h0000000000000000, 3'd1, 64'd0, 5'h00});
    q.push_back('{64'h8000000000000000, 64'h0000000000000000, 3'd0, 64'd1, 5'h00});
    q.push_back('{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 64'd0, 5'h00});
    q.push_back('{64'h7FF0000000000001, 64'h3FF0000000000000, 3'd2, 64'd0, 5'h10});
    q.push_back('{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd1, 64'd0, 5'h10});
`ifdef FP_CMP_MINMAX_EN
    q.push_back('{64'h8000000000000000, 64'h0000000000000000, 3'd3, 64'h8000000000000000, 5'h00});
    q.push_back('{64'h7FF8000000000000, 64'hC000000000000000, 3'd4, 64'hC000000000000000, 5'h00});
    q.push_back('{64'h7FF0000000000001, 64'h7FF0000000000002, 3'd4, 64'h7FF8000000000000, 5'h10});
`else
    q.push_back('{64'h8000000000000000, 64'h0000000000000000, 3'd3, 64'd0, 5'h00});
`endif
    check_table("double", q, 1'b1);
  endtask

  // With out_ready held high the results must leave on consecutive cycles.
  task automatic test_throughput();
    int seen, first, last;
    apply_reset();
    seen = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b1;
      in_valid  = (i < 6);
      a64 = {32'd0, 32'h3F800000};
      b64 = {32'd0, 32'h40000000};
      in_op  = 3'd1;
      in_tag = 4'(i);
      #1;
      if (out_valid_s) begin
        if (first < 0) first = i;
        last = i;
        seen++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 6 || first !== 2 || last !== 7) begin
      errors++;
      $display("[TB] FAIL throughput: got seen=%0d first=%0d last=%0d, expected 6/2/7", seen, first, last);
    end
  endtask

  task automatic test_back_to_back(input int n_ops, input bit stall_pattern);
    logic [31:0] exp_res[$];
    logic [4:0]  exp_flg[$];
    logic [3:0]  exp_tag[$];
    logic [31:0] a, b, held_res;
    logic [4:0]  held_flg;
    logic [3:0]  held_tag;
    logic [63:0] m_res;
    logic [4:0]  m_fl;
    int issued, cyc;
    bit prev_stall, saw_block;
    apply_reset();
    issued = 0; cyc = 0; prev_stall = 0; saw_block = 0;
    held_res = '0; held_flg = '0; held_tag = '0;
    b = 32'h3F800000;
    while ((issued < n_ops || exp_res.size() > 0) && cyc < n_ops * 10 + 50) begin
      out_ready = stall_pattern ? (cyc % 3 == 0) : 1'b1;
      if (issued < n_ops) begin
        a = gen_operand(b);
        b = gen_operand(a);
        a64 = {32'd0, a};
        b64 = {32'd0, b};
        in_op    = 3'($urandom_range(0, 7));
        in_tag   = 4'(issued);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready_s !== ((exp_res.size() < 2) || out_ready)) begin
        errors++;
        $display("[TB] FAIL in_ready@%0d: got %b expected %b", cyc, in_ready_s, (exp_res.size() < 2) || out_ready);
      end
      if (!in_ready_s) saw_block = 1;
      if (prev_stall) begin
        checks++;
        if (out_valid_s !== 1'b1 || out_result_s !== held_res || out_flags_s !== held_flg || out_tag_s !== held_tag) begin
          errors++;
          $display("[TB] FAIL stall_hold@%0d: got v=%b r=%h f=%h t=%h, expected v=1 r=%h f=%h t=%h", cyc,
                   out_valid_s, out_result_s, out_flags_s, out_tag_s, held_res, held_flg, held_tag);
        end
      end
      if (out_valid_s) begin
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("[TB] FAIL spurious@%0d: got result t=%h, expected none", cyc, out_tag_s);
        end else begin
          if (out_result_s !== exp_res[0] || out_flags_s !== exp_flg[0] || out_tag_s !== exp_tag[0]) begin
            errors++;
            $display("[TB] FAIL stream@%0d: got r=%h f=%h t=%h, expected r=%h f=%h t=%h", cyc,
                     out_result_s, out_flags_s, out_tag_s, exp_res[0], exp_flg[0], exp_tag[0]);
          end
          if (out_ready) begin
            void'(exp_res.pop_front());
            void'(exp_flg.pop_front());
            void'(exp_tag.pop_front());
          end
        end
      end
      prev_stall = out_valid_s && !out_ready;
      held_res = out_result_s;
      held_flg = out_flags_s;
      held_tag = out_tag_s;
      if (in_valid && in_ready_s) begin
        ref_model(a64, b64, in_op, 8, 23, m_res, m_fl);
        exp_res.push_back(m_res[31:0]);
        exp_flg.push_back(m_fl);
        exp_tag.push_back(in_tag);
        issued++;
      end
      cyc++;
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (exp_res.size() != 0 || issued != n_ops) begin
      errors++;
      $display("[TB] FAIL drain: got pending=%0d issued=%0d, expected pending=0 issued=%0d",
               exp_res.size(), issued, n_ops);
    end
    if (stall_pattern) begin
      checks++;
      if (!saw_block) begin
        errors++;
        $display("[TB] FAIL backpressure: got in_ready never low, expected it to drop with 2 buffered");
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    out_ready = 1'b0;
    a64 = {32'd0, 32'h3F800000};
    b64 = {32'd0, 32'h40000000};
    in_op = 3'd1;
    for (int i = 0; i < 2; i++) begin
      in_tag   = 4'(9 + i);
      in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL preload: got v=%b in_ready=%b, expected v=1 in_ready=0", out_valid_s, in_ready_s);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (out_valid_s !== 1'b0 || out_result_s !== 32'd0 || out_tag_s !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: got v=%b r=%h t=%h, expected v=0 r=0 t=0",
               out_valid_s, out_result_s, out_tag_s);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid_s !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stale_result[%0d]: got v=1 t=%h, expected v=0", i, out_tag_s);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_compare_sp();
    test_minmax_sp();
    test_double();
    test_throughput();
    test_back_to_back(8, 1'b1);
    test_back_to_back(200, 1'b1);
    test_back_to_back(100, 1'b0);
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
